// File: rtl/fpa_pkg.sv
// Shared types and constants for the multi-cycle single-precision add/subtract sequencer.
// Also holds the operand swap/split/shift helpers used at accept and during alignment.
package fpa_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;
    localparam int SIG_W = MAN_W + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_ZERO      = 0;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
        logic             is_nan;
        logic             is_inf;
    } operand_t;

    // Denormals get a zero hidden bit; specials are tagged so ALIGN can short-circuit.
    function automatic operand_t split(input logic [31:0] x);
        operand_t o;
        o.sign   = x[31];
        o.exp    = x[30:23];
        o.sig    = {|x[30:23], x[22:0]};
        o.is_nan = (x[30:23] == EXP_MAX) && (x[22:0] != '0);
        o.is_inf = (x[30:23] == EXP_MAX) && (x[22:0] == '0);
        return o;
    endfunction

    function automatic logic swap_needed(input logic [31:0] a, input logic [31:0] b);
        return b[30:0] > a[30:0];
    endfunction

    // Truncating right shift; any amount of SIG_W or more yields zero.
    function automatic logic [SIG_W-1:0] shift_right(input logic [SIG_W-1:0] sig,
                                                     input logic [EXP_W-1:0] amt);
        return (amt >= EXP_W'(SIG_W)) ? '0 : (sig >> amt);
    endfunction

endpackage

// File: rtl/fpa_norm_step.sv
// One normalisation decision: either finish the result or shift the sum left one place.
// Purely combinational; the sequencer registers everything it produces.
module fpa_norm_step
    import fpa_pkg::*;
(
    input  logic             sign,
    input  logic [EXP_W-1:0] exp,
    input  logic [SIG_W:0]   sum,
    output logic             done,
    output logic [SIG_W:0]   next_sum,
    output logic [EXP_W-1:0] next_exp,
    output logic [31:0]      result,
    output logic [3:0]       flags
);

    logic [EXP_W-1:0] exp_inc;
    logic [EXP_W-1:0] exp_dec;

    assign exp_inc = exp + EXP_W'(1);
    assign exp_dec = exp - EXP_W'(1);

    always_comb begin
        done     = 1'b0;
        next_sum = sum;
        next_exp = exp;
        result   = {sign, exp, sum[MAN_W-1:0]};
        flags    = '0;
        if (sum == '0) begin
            done             = 1'b1;
            result           = '0;
            flags[FLAG_ZERO] = 1'b1;
        end else if (sum[SIG_W]) begin
            // Carry out of the add: one right shift always suffices.
            done     = 1'b1;
            next_sum = sum >> 1;
            next_exp = exp_inc;
            if (exp_inc == EXP_MAX) begin
                result               = {sign, EXP_MAX, {MAN_W{1'b0}}};
                flags[FLAG_OVERFLOW] = 1'b1;
            end else begin
                result = {sign, exp_inc, sum[MAN_W:1]};
            end
        end else if (sum[SIG_W-1]) begin
            done = 1'b1;
        end else if (exp == EXP_W'(1)) begin
            done                  = 1'b1;
            result                = {sign, {EXP_W{1'b0}}, sum[MAN_W-1:0]};
            flags[FLAG_UNDERFLOW] = 1'b1;
        end else begin
            next_sum = sum << 1;
            next_exp = exp_dec;
        end
    end

endmodule

// File: rtl/fpa_seq_ctrl.sv
// Multi-cycle IEEE-754 single-precision add/subtract sequencer: accept, align, add,
// iterative normalise, then hold the result until the consumer takes it.
module fpa_seq_ctrl
    import fpa_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_flags,
    output logic        busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // in_ready is high only in IDLE; out_valid rises on entry to DONE and, with result
    // and flags, stays unchanged until out_ready is seen.

    state_t           state;
    operand_t         op_a;
    operand_t         op_b;
    logic [SIG_W:0]   sum;
    logic [EXP_W-1:0] exp_r;
    logic             sign_r;

    logic [31:0]      b_signed;
    logic             do_swap;
    logic [EXP_W-1:0] ediff;

    logic             norm_done;
    logic [SIG_W:0]   norm_sum;
    logic [EXP_W-1:0] norm_exp;
    logic [31:0]      norm_result;
    logic [3:0]       norm_flags;

    assign b_signed = {in_b[31] ^ in_sub, in_b[30:0]};
    assign do_swap  = swap_needed(in_a, b_signed);
    assign ediff    = op_a.exp - op_b.exp;
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    fpa_norm_step u_norm (
        .sign     (sign_r),
        .exp      (exp_r),
        .sum      (sum),
        .done     (norm_done),
        .next_sum (norm_sum),
        .next_exp (norm_exp),
        .result   (norm_result),
        .flags    (norm_flags)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op_a       <= '0;
            op_b       <= '0;
            sum        <= '0;
            exp_r      <= '0;
            sign_r     <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a  <= do_swap ? split(b_signed) : split(in_a);
                        op_b  <= do_swap ? split(in_a) : split(b_signed);
                        state <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (op_a.is_nan || op_b.is_nan ||
                        (op_a.is_inf && op_b.is_inf && (op_a.sign != op_b.sign))) begin
                        out_result <= QNAN;
                        out_flags  <= 4'(1 << FLAG_INVALID);
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end else if (op_a.is_inf || op_b.is_inf) begin
                        // After the swap a finite A can never sit beside an infinite B.
                        out_result <= {op_a.sign, EXP_MAX, {MAN_W{1'b0}}};
                        out_flags  <= '0;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        op_b.sig <= shift_right(op_b.sig, ediff);
                        state    <= ADD;
                    end
                end
                ADD: begin
                    sum    <= (op_a.sign == op_b.sign) ? ({1'b0, op_a.sig} + {1'b0, op_b.sig})
                                                       : ({1'b0, op_a.sig} - {1'b0, op_b.sig});
                    sign_r <= op_a.sign;
                    exp_r  <= (op_a.exp == '0) ? EXP_W'(1) : op_a.exp;
                    state  <= NORM;
                end
                NORM: begin
                    sum   <= norm_sum;
                    exp_r <= norm_exp;
                    if (norm_done) begin
                        out_result <= norm_result;
                        out_flags  <= norm_flags;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpa_seq_ctrl.sv
// Bench for fpa_seq_ctrl: directed vector table, hand-written hold and reset sequences,
// and random operands checked against an arithmetic reference model.
module tb_fpa_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [35:0] exp_q[$];
    int          lat_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic [3:0]  fl;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    fpa_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sub     (in_sub),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .busy       (busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference model: real significand arithmetic, leading-one search for normalisation.
    function automatic void model(input logic [31:0] ai, input logic [31:0] bi, input logic sub,
                                  output logic [31:0] res, output logic [3:0] fl, output int lat);
        logic [31:0] a, b, t;
        logic        sa, sb;
        int          ea, eb, e, d, p, need, k;
        longint      ma, mb, s;
        bit          nan_a, nan_b, inf_a, inf_b;
        a = ai;
        b = bi;
        b[31] = b[31] ^ sub;
        if (b[30:0] > a[30:0]) begin t = a; a = b; b = t; end
        sa = a[31];
        sb = b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        nan_a = (ea == 255) && (a[22:0] != 0);
        nan_b = (eb == 255) && (b[22:0] != 0);
        inf_a = (ea == 255) && (a[22:0] == 0);
        inf_b = (eb == 255) && (b[22:0] == 0);
        fl  = 4'b0000;
        lat = 2;
        if (nan_a || nan_b || (inf_a && inf_b && sa != sb)) begin
            res = 32'h7FC0_0000;
            fl  = 4'b1000;
            return;
        end
        if (inf_a || inf_b) begin
            res = {sa, 8'hFF, 23'h0};
            return;
        end
        ma = longint'(a[22:0]) + ((ea != 0) ? 64'd8388608 : 64'd0);
        mb = longint'(b[22:0]) + ((eb != 0) ? 64'd8388608 : 64'd0);
        d  = ea - eb;
        mb = (d >= 25) ? 64'd0 : (mb >> d);
        s  = (sa == sb) ? (ma + mb) : (ma - mb);
        e  = (ea == 0) ? 1 : ea;
        lat = 4;
        if (s == 0) begin
            res = 32'h0;
            fl  = 4'b0001;
            return;
        end
        if (s >= 64'd16777216) begin
            e = e + 1;
            if (e == 255) begin
                res = {sa, 8'hFF, 23'h0};
                fl  = 4'b0100;
            end else begin
                res = {sa, 8'(e), 23'(s >> 1)};
            end
            return;
        end
        p = 0;
        while ((64'd1 << (p + 1)) <= s) p++;
        need = 23 - p;
        if (need <= e - 1) begin
            res = {sa, 8'(e - need), 23'(s << need)};
            lat = 4 + need;
        end else begin
            k   = e - 1;
            res = {sa, 8'h00, 23'(s << k)};
            fl  = 4'b0010;
            lat = 4 + k;
        end
    endfunction

    // ---------------- driver ----------------
    // Expected {flags,result} and latency come from exp_q/lat_q. With junk set, in_valid
    // stays high with garbage operands while the operation is in flight.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input int hold, input bit junk, input string tag);
        logic [35:0] e;
        int          elat;
        int          n;
        bit          seen;
        logic [31:0] held_res;
        logic [3:0]  held_fl;
        e    = exp_q.pop_front();
        elat = lat_q.pop_front();
        @(negedge clk);
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        if (junk) begin
            in_a   = $urandom;
            in_b   = $urandom;
            in_sub = 1'($urandom_range(0, 1));
        end else begin
            in_valid = 1'b0;
        end
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 80) begin
            @(negedge clk);
            n++;
            if (out_valid) seen = 1'b1;
        end
        check({tag, " out_valid seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, " latency"}, n, elat);
            check({tag, " result"}, out_result, e[31:0]);
            check({tag, " flags"}, 32'(out_flags), 32'(e[35:32]));
            held_res = out_result;
            held_fl  = out_flags;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check({tag, " hold result"}, out_result, held_res);
                check({tag, " hold flags"}, 32'(out_flags), 32'(held_fl));
                check({tag, " hold valid"}, 32'(out_valid), 32'd1);
                check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " idle valid"}, 32'(out_valid), 32'd0);
        check({tag, " idle in_ready"}, 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] ra, rb, mres;
        logic [3:0]  mfl;
        logic        rsub;
        int          mlat, ea, eb;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        out_ready = 1'b0;

        vecs.push_back('{32'h40C00000, 32'h41000000, 1'b0, 32'h41600000, 4'b0000, 4});
        vecs.push_back('{32'h411C0000, 32'h3F100000, 1'b0, 32'h41250000, 4'b0000, 4});
        vecs.push_back('{32'hC0C00000, 32'h41000000, 1'b0, 32'h40000000, 4'b0000, 6});
        vecs.push_back('{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0001, 4});
        vecs.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0100, 4});
        vecs.push_back('{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, 2});
        vecs.push_back('{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000, 2});
        vecs.push_back('{32'hFF800000, 32'hFF800000, 1'b1, 32'h7FC00000, 4'b1000, 2});
        vecs.push_back('{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000, 2});
        vecs.push_back('{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'b0010, 4});
        vecs.push_back('{32'h00C00000, 32'h00800000, 1'b1, 32'h00400000, 4'b0010, 4});
        vecs.push_back('{32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h34000000, 4'b0000, 27});
        vecs.push_back('{32'h4B000000, 32'h3F800000, 1'b0, 32'h4B000001, 4'b0000, 4});
        vecs.push_back('{32'h4F000000, 32'h3F800000, 1'b0, 32'h4F000000, 4'b0000, 4});
        vecs.push_back('{32'hBF800000, 32'h3F000000, 1'b0, 32'hBF000000, 4'b0000, 5});

        #12;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset result", out_result, 32'd0);
        check("reset flags", 32'(out_flags), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            exp_q.push_back({vecs[i].fl, vecs[i].res});
            lat_q.push_back(vecs[i].lat);
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, 0, 1'b0, $sformatf("vec%0d", i));
        end

        // inf + -inf with the consumer stalling for three cycles
        exp_q.push_back({4'b1000, 32'h7FC00000});
        lat_q.push_back(2);
        run_op(32'h7F800000, 32'hFF800000, 1'b0, 3, 1'b0, "inf_hold");

        // reset while the -6+8 case is still normalising
        @(negedge clk);
        in_a     = 32'hC0C00000;
        in_b     = 32'h41000000;
        in_sub   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_norm busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_norm rst out_valid", 32'(out_valid), 32'd0);
        check("mid_norm rst in_ready", 32'(in_ready), 32'd1);
        check("mid_norm rst busy", 32'(busy), 32'd0);
        check("mid_norm rst result", out_result, 32'd0);
        check("mid_norm rst flags", 32'(out_flags), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst out_valid", 32'(out_valid), 32'd0);
        exp_q.push_back({4'b0000, 32'h41600000});
        lat_q.push_back(4);
        run_op(32'h40C00000, 32'h41000000, 1'b0, 0, 1'b0, "post_rst");

        // random operands, producer keeps in_valid high with junk while busy
        for (int r = 0; r < 40; r++) begin
            ea = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 255)
                                             : int'($urandom_range(1, 254));
            if ($urandom_range(0, 3) == 0) eb = int'($urandom_range(0, 255));
            else eb = ea + int'($urandom_range(0, 6)) - 3;
            if (eb < 0) eb = 0;
            if (eb > 255) eb = 255;
            ra   = {1'($urandom_range(0, 1)), 8'(ea), 23'($urandom_range(0, 32'h7FFFFF))};
            rb   = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom_range(0, 32'h7FFFFF))};
            rsub = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) begin
                rb[30:0] = ra[30:0];
                rb[31]   = ra[31] ^ ~rsub;
            end
            model(ra, rb, rsub, mres, mfl, mlat);
            exp_q.push_back({mfl, mres});
            lat_q.push_back(mlat);
            run_op(ra, rb, rsub, int'($urandom_range(0, 2)), 1'b1, $sformatf("rand%0d", r));
        end

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
